// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

   localparam int UART_DW = 8;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE,
      HOLD
   } uart_arb_state_t;

   // Width of a counter that must be able to hold max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         gnt_onehot,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       any
);

   localparam int IW = $clog2(NUM_REQ);

   logic [IW-1:0] cand_idx [NUM_REQ];

   // cand_idx[k] is the requester k places after the pointer, modulo NUM_REQ.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [IW:0] sum;
         assign sum = {1'b0, ptr} + (IW + 1)'(gi);
         assign cand_idx[gi] = (sum >= (IW + 1)'(NUM_REQ)) ?
                               IW'(sum - (IW + 1)'(NUM_REQ)) : IW'(sum);
      end
   endgenerate

   always_comb begin
      gnt_idx    = '0;
      any        = 1'b0;
      gnt_onehot = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[cand_idx[k]]) begin
            gnt_idx = cand_idx[k];
            any     = 1'b1;
         end
      end
      if (any) begin
         gnt_onehot[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer among NUM_REQ byte-stream requesters with
// round-robin arbitration and a packet lock held until a byte tagged last.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int LOCK_TIMEOUT = 0,
   parameter int START_WAIT   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [UART_DW*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [UART_DW-1:0]           tx_data,
   output logic                         tx_wr,
   input  logic                         tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         locked,
   output logic                         start_err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int SW = cnt_width(START_WAIT);
   localparam int LW = cnt_width(LOCK_TIMEOUT);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

   uart_arb_state_t    state_reg;
   logic [IW-1:0]      ptr_reg;
   logic [SW-1:0]      start_cnt_reg;
   logic [LW-1:0]      stall_cnt_reg;

   logic [UART_DW-1:0] lane_data [NUM_REQ];
   logic [NUM_REQ-1:0] arb_onehot;
   logic [NUM_REQ-1:0] hold_onehot;
   logic [IW-1:0]      arb_idx;
   logic [IW-1:0]      ptr_next;
   logic               arb_any;
   logic [SW-1:0]      start_cnt_next;
   logic [LW-1:0]      stall_cnt_next;
   logic               start_expired;
   logic               stall_expired;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign lane_data[gi]   = req_data[gi*UART_DW +: UART_DW];
         assign hold_onehot[gi] = (grant_id == IW'(gi));
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req        (req_valid),
      .ptr        (ptr_reg),
      .gnt_onehot (arb_onehot),
      .gnt_idx    (arb_idx),
      .any        (arb_any)
   );

   assign ptr_next       = (grant_id == LAST_IDX) ? '0 : grant_id + IW'(1);
   assign start_cnt_next = start_cnt_reg + SW'(1);
   assign stall_cnt_next = stall_cnt_reg + LW'(1);
   // The start counter runs from the write strobe, so a busy rise seen up to
   // START_WAIT cycles after tx_wr is still accepted.
   assign start_expired  = (start_cnt_next == SW'(START_WAIT));
   assign stall_expired  = (LOCK_TIMEOUT > 0) && (stall_cnt_next == LW'(LOCK_TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         start_cnt_reg <= '0;
         stall_cnt_reg <= '0;
         req_ready     <= '0;
         tx_data       <= '0;
         tx_wr         <= 1'b0;
         grant_id      <= '0;
         locked        <= 1'b0;
         start_err     <= 1'b0;
      end else begin
         tx_wr     <= 1'b0;
         req_ready <= '0;
         case (state_reg)
            IDLE: begin
               // The serializer has no reset, so it may still be shifting a byte.
               if (!tx_busy && arb_any) begin
                  grant_id      <= arb_idx;
                  tx_data       <= lane_data[arb_idx];
                  locked        <= ~req_last[arb_idx];
                  req_ready     <= arb_onehot;
                  tx_wr         <= 1'b1;
                  start_cnt_reg <= '0;
                  state_reg     <= ISSUE;
               end
            end
            ISSUE: begin
               start_cnt_reg <= start_cnt_next;
               if (start_expired) begin
                  start_err <= 1'b1;
                  state_reg <= WAIT_DONE;
               end else begin
                  state_reg <= WAIT_START;
               end
            end
            WAIT_START: begin
               if (tx_busy) begin
                  state_reg <= WAIT_DONE;
               end else begin
                  start_cnt_reg <= start_cnt_next;
                  if (start_expired) begin
                     start_err <= 1'b1;
                     state_reg <= WAIT_DONE;
                  end
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (locked) begin
                     stall_cnt_reg <= '0;
                     state_reg     <= HOLD;
                  end else begin
                     ptr_reg   <= ptr_next;
                     state_reg <= IDLE;
                  end
               end
            end
            HOLD: begin
               if (req_valid[grant_id]) begin
                  tx_data       <= lane_data[grant_id];
                  locked        <= ~req_last[grant_id];
                  req_ready     <= hold_onehot;
                  tx_wr         <= 1'b1;
                  start_cnt_reg <= '0;
                  state_reg     <= ISSUE;
               end else begin
                  stall_cnt_reg <= stall_cnt_next;
                  if (stall_expired) begin
                     locked    <= 1'b0;
                     ptr_reg   <= ptr_next;
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a behavioural
// serializer (busy rises 2 cycles after tx_wr, stays high 100 cycles).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int LOCK_TIMEOUT = 16;
   localparam int START_WAIT   = 8;
   localparam int BUSY_LEN     = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_last = '0;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_busy = 1'b0;
   logic [1:0]  grant_id;
   logic        locked;
   logic        start_err;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .START_WAIT   (START_WAIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_wr     (tx_wr),
      .tx_busy   (tx_busy),
      .grant_id  (grant_id),
      .locked    (locked),
      .start_err (start_err)
   );

   // Requester queues: push only moves tail, the driver only moves head.
   logic [8:0] fifo [4][32];
   int head [4] = '{default: 0};
   int tail [4] = '{default: 0};
   int ready_log [64];
   int n_ready = 0;
   int ready_bad = 0;

   always @(negedge clk) begin
      if (req_ready != 4'b0000 && !$onehot(req_ready)) ready_bad++;
      for (int i = 0; i < 4; i++) begin
         if (req_ready[i]) begin
            if (n_ready < 64) ready_log[n_ready] = i;
            n_ready++;
            head[i]++;
         end
         if (head[i] < tail[i]) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = fifo[i][head[i]][7:0];
            req_last[i]        = fifo[i][head[i]][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   end

   // Serializer model and write log.
   int cyc = 0;
   int wr_count = 0;
   int rise_in = 0;
   int busy_left = 0;
   int last_fall = -1000;
   int viol = 0;
   int wr_while_busy = 0;
   bit armed = 1'b0;
   bit model_mute = 1'b0;
   logic [7:0] wr_data_log [64];
   logic [1:0] wr_gnt_log  [64];
   int         wr_gap_log  [64];

   always @(negedge clk) begin
      cyc++;
      if (rise_in > 0) begin
         rise_in--;
         if (rise_in == 0 && !model_mute) begin
            tx_busy   = 1'b1;
            busy_left = BUSY_LEN;
            armed     = 1'b0;
         end
      end else if (tx_busy) begin
         busy_left--;
         if (busy_left == 0) begin
            tx_busy   = 1'b0;
            last_fall = cyc;
         end
      end
      if (tx_wr) begin
         $display("tx byte %02h from req %0d at cycle %0d", tx_data, grant_id, cyc);
         if (wr_count < 64) begin
            wr_data_log[wr_count] = tx_data;
            wr_gnt_log[wr_count]  = grant_id;
            wr_gap_log[wr_count]  = cyc - last_fall;
         end
         wr_count++;
         if (armed) viol++;
         if (tx_busy) wr_while_busy++;
         armed   = 1'b1;
         rise_in = 2;
      end
      if (start_err) armed = 1'b0;
   end

   task automatic push(input int i, input logic [7:0] d, input logic l);
      fifo[i][tail[i]] = {l, d};
      tail[i]++;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   task automatic wait_wr(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (wr_count >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      bit empty;
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         empty = 1'b1;
         for (int i = 0; i < 4; i++) if (head[i] != tail[i]) empty = 1'b0;
         if (!tx_busy && rise_in == 0 && empty) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({tx_wr, req_ready, tx_data, grant_id, locked, start_err} !== 17'd0)
         $display("FAIL reset_hold: outputs %h want 0", {tx_wr, req_ready, tx_data, grant_id, locked, start_err});
      else passed++;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk); #1;
      total++;
      if ({tx_wr, req_ready, tx_data, grant_id, locked, start_err} !== 17'd0)
         $display("FAIL reset_release: outputs %h want 0", {tx_wr, req_ready, tx_data, grant_id, locked, start_err});
      else passed++;
   endtask

   task automatic test_single_byte();
      bit ok;
      int base = wr_count;
      @(posedge clk); #2;
      push(0, 8'h41, 1'b1);
      @(negedge clk); #1;
      total++;
      if (tx_wr !== 1'b0) $display("FAIL single_early_wr: got %b want 0", tx_wr);
      else passed++;
      @(negedge clk); #1;
      total++;
      if ({tx_wr, tx_data, req_ready, grant_id, locked} !== {1'b1, 8'h41, 4'b0001, 2'd0, 1'b0})
         $display("FAIL single_issue: wr/data/ready/gnt/lock %h want %h",
                  {tx_wr, tx_data, req_ready, grant_id, locked}, {1'b1, 8'h41, 4'b0001, 2'd0, 1'b0});
      else passed++;
      @(negedge clk); #1;
      total++;
      if ({tx_wr, req_ready} !== 5'b0) $display("FAIL single_pulse: wr/ready %b want 00000", {tx_wr, req_ready});
      else passed++;
      wait_idle(300, ok);
      total++;
      if (!ok) $display("FAIL single_timeout: busy never cleared");
      else passed++;
      total++;
      if (wr_count - base !== 1 || locked !== 1'b0)
         $display("FAIL single_count: writes %0d locked %b want 1 and 0", wr_count - base, locked);
      else passed++;
   endtask

   task automatic test_contention();
      bit ok;
      int base;
      int rbase;
      do_reset();
      base  = wr_count;
      rbase = n_ready;
      for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i), 1'b1);
      wait_wr(base + 4, 1000, ok);
      total++;
      if (!ok) $display("FAIL contention_timeout: got %0d writes want 4", wr_count - base);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (wr_data_log[base+i] !== 8'hA0 + 8'(i) || wr_gnt_log[base+i] !== 2'(i) || ready_log[rbase+i] !== i)
            $display("FAIL contention_order%0d: data %h gnt %0d ready %0d want %h %0d %0d",
                     i, wr_data_log[base+i], wr_gnt_log[base+i], ready_log[rbase+i], 8'hA0 + 8'(i), i, i);
         else passed++;
      end
      wait_idle(300, ok);
   endtask

   // Runs straight after contention: pointer must have wrapped back to 0.
   task automatic test_packet_lock();
      bit ok;
      int base = wr_count;
      int rbase = n_ready;
      logic [7:0] exp_d [4];
      logic [1:0] exp_g [4];
      exp_d = '{8'hB0, 8'hB1, 8'hB2, 8'hC0};
      exp_g = '{2'd0, 2'd0, 2'd0, 2'd1};
      push(0, 8'hB0, 1'b0);
      push(0, 8'hB1, 1'b0);
      push(0, 8'hB2, 1'b1);
      push(1, 8'hC0, 1'b1);
      wait_wr(base + 1, 20, ok);
      total++;
      if (!ok || locked !== 1'b1) $display("FAIL lock_set: ok %b locked %b want 1 1", ok, locked);
      else passed++;
      wait_wr(base + 4, 1000, ok);
      total++;
      if (!ok) $display("FAIL lock_timeout_wait: got %0d writes want 4", wr_count - base);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (wr_data_log[base+i] !== exp_d[i] || wr_gnt_log[base+i] !== exp_g[i] || ready_log[rbase+i] !== int'(exp_g[i]))
            $display("FAIL lock_order%0d: data %h gnt %0d ready %0d want %h %0d",
                     i, wr_data_log[base+i], wr_gnt_log[base+i], ready_log[rbase+i], exp_d[i], exp_g[i]);
         else passed++;
      end
      total++;
      if (wr_gap_log[base+1] !== 2 || wr_gap_log[base+2] !== 2)
         $display("FAIL lock_b2b_gap: gaps %0d %0d want 2 2", wr_gap_log[base+1], wr_gap_log[base+2]);
      else passed++;
      wait_idle(300, ok);
      total++;
      if (locked !== 1'b0) $display("FAIL lock_release: locked %b want 0", locked);
      else passed++;
   endtask

   task automatic test_lock_timeout();
      bit ok;
      int base;
      int rbase;
      int fb;
      do_reset();
      base  = wr_count;
      rbase = n_ready;
      push(0, 8'hD0, 1'b0);
      push(2, 8'hE0, 1'b1);
      wait_wr(base + 1, 20, ok);
      fb = last_fall;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk); #1;
         if (last_fall != fb) break;
      end
      total++;
      if (last_fall == fb) $display("FAIL tmo_busy_fall: busy never fell");
      else passed++;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk); #1;
         if (k == 16) begin
            total++;
            if (locked !== 1'b1) $display("FAIL tmo_hold15: locked %b want 1", locked);
            else passed++;
         end
         if (k == 17) begin
            total++;
            if (locked !== 1'b0) $display("FAIL tmo_drop16: locked %b want 0", locked);
            else passed++;
         end
      end
      wait_wr(base + 2, 10, ok);
      total++;
      if (!ok || wr_data_log[base+1] !== 8'hE0 || wr_gnt_log[base+1] !== 2'd2 || wr_gap_log[base+1] !== 18 || ready_log[rbase+1] !== 2)
         $display("FAIL tmo_regrant: ok %b data %h gnt %0d gap %0d want 1 e0 2 18",
                  ok, wr_data_log[base+1], wr_gnt_log[base+1], wr_gap_log[base+1]);
      else passed++;
      wait_idle(300, ok);
   endtask

   task automatic test_start_error();
      bit ok;
      int base;
      do_reset();
      base = wr_count;
      model_mute = 1'b1;
      push(1, 8'hF0, 1'b1);
      wait_wr(base + 1, 20, ok);
      for (int k = 1; k <= START_WAIT; k++) begin
         @(negedge clk); #1;
         if (k == START_WAIT - 1) begin
            total++;
            if (start_err !== 1'b0) $display("FAIL serr_early: start_err %b want 0", start_err);
            else passed++;
         end
         if (k == START_WAIT) begin
            total++;
            if (start_err !== 1'b1) $display("FAIL serr_set: start_err %b want 1", start_err);
            else passed++;
         end
      end
      repeat (30) @(negedge clk);
      #1;
      total++;
      if (wr_count - base !== 1 || start_err !== 1'b1 || viol !== 0 || ready_bad !== 0)
         $display("FAIL serr_after: writes %0d serr %b viol %0d ready_bad %0d want 1 1 0 0",
                  wr_count - base, start_err, viol, ready_bad);
      else passed++;
      model_mute = 1'b0;
   endtask

   task automatic test_reset_mid_byte();
      bit ok;
      int wc;
      total++;
      if (start_err !== 1'b1) $display("FAIL mid_sticky: start_err %b want 1", start_err);
      else passed++;
      push(3, 8'h47, 1'b1);
      wait_wr(wr_count + 1, 20, ok);
      repeat (12) @(negedge clk);
      #1;
      push(2, 8'h48, 1'b1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({tx_wr, req_ready, tx_data, grant_id, locked, start_err} !== 17'd0 || tx_busy !== 1'b1)
         $display("FAIL mid_async: outputs %h busy %b want 0 1",
                  {tx_wr, req_ready, tx_data, grant_id, locked, start_err}, tx_busy);
      else passed++;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      wc = wr_count;
      for (int k = 0; k < 200 && tx_busy; k++) begin
         @(negedge clk); #1;
      end
      total++;
      if (wr_count !== wc || wr_while_busy !== 0)
         $display("FAIL mid_no_wr: writes %0d while_busy %0d want 0 0", wr_count - wc, wr_while_busy);
      else passed++;
      wait_wr(wc + 1, 10, ok);
      total++;
      if (!ok || wr_data_log[wc] !== 8'h48 || wr_gnt_log[wc] !== 2'd2)
         $display("FAIL mid_resume: ok %b data %h gnt %0d want 1 48 2", ok, wr_data_log[wc], wr_gnt_log[wc]);
      else passed++;
      wait_idle(300, ok);
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_contention();
      test_packet_lock();
      test_lock_timeout();
      test_start_error();
      test_reset_mid_byte();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", passed, total);
      $fatal(1);
   end

endmodule
